// File: rtl/pb_pkg.sv
// Shared types and defaults for the pushbutton conditioner: per-bit debounce
// state encoding and default synchroniser/debounce depths.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'b00,
        CONFIRM_HIGH = 2'b01,
        IDLE_HIGH    = 2'b10,
        CONFIRM_LOW  = 2'b11
    } pb_state_e;

    localparam int PB_SYNC_STAGES_DEFAULT     = 2;
    localparam int PB_DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/debounce_bit.sv
// One button bit: synchroniser chain, 4-state debounce FSM with counter, and
// registered press/release pulses. Build macro PB_ACTIVE_LOW_EN inverts the raw input.
module debounce_bit
    import pb_pkg::*;
#(
    parameter int SYNC_STAGES     = PB_SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic debounced,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                   button_in;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    pb_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   debounced_q;
    logic                   press_q;
    logic                   release_q;

    // Inversion happens ahead of the first flop so reset still means "released".
`ifdef PB_ACTIVE_LOW_EN
    assign button_in = ~button_raw;
`else
    assign button_in = button_raw;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE_LOW;
            cnt_q       <= '0;
            debounced_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (sync_bit) begin
                        state_q <= CONFIRM_HIGH;
                        cnt_q   <= CNT_ONE;
                    end
                end
                CONFIRM_HIGH: begin
                    if (!sync_bit) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE_HIGH;
                        cnt_q       <= '0;
                        debounced_q <= 1'b1;
                        press_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_bit) begin
                        state_q <= CONFIRM_LOW;
                        cnt_q   <= CNT_ONE;
                    end
                end
                CONFIRM_LOW: begin
                    if (sync_bit) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE_LOW;
                        cnt_q       <= '0;
                        debounced_q <= 1'b0;
                        release_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign debounced     = debounced_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Synchronises and debounces WIDTH raw buttons, then phase-aligns the result so
// the processor sees a stable nibble through execute. Honours PB_ACTIVE_LOW_EN.
module pushbutton_conditioner
    import pb_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = PB_SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             phase,
    input  logic [WIDTH-1:0] buttons_raw,
    output logic [WIDTH-1:0] pushbuttons,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] debounced
);

    logic [WIDTH-1:0] pushbuttons_q;
    logic [WIDTH-1:0] pushbuttons_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clock        (clock),
            .reset        (reset),
            .button_raw   (buttons_raw[gi]),
            .debounced    (debounced[gi]),
            .press_pulse  (press_pulse[gi]),
            .release_pulse(release_pulse[gi])
        );
    end

    // Only fetch-phase edges may update what IN will read during execute.
    assign pushbuttons_d = phase ? pushbuttons_q : debounced;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pushbuttons_q <= '0;
        end else begin
            pushbuttons_q <= pushbuttons_d;
        end
    end

    assign pushbuttons = pushbuttons_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Bench for pushbutton_conditioner (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
// directed table, corner-case sequences and random stimulus against a run-length model.
module tb_pushbutton_conditioner;

    localparam int W    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic         clock;
    logic         reset;
    logic         phase;
    logic [W-1:0] buttons_raw;
    logic [W-1:0] pushbuttons;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;
    logic [W-1:0] debounced;

    int checks = 0;
    int errors = 0;

    pushbutton_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .phase        (phase),
        .buttons_raw  (buttons_raw),
        .pushbuttons  (pushbuttons),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .debounced    (debounced)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a bit commits once its synchronised value has disagreed
    // with the debounced level for DEB consecutive edges.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_deb, m_press, m_rel, m_pb;
    int           m_run[W];

    function automatic logic [W-1:0] to_raw(input logic [W-1:0] pressed);
`ifdef PB_ACTIVE_LOW_EN
        return ~pressed;
`else
        return pressed;
`endif
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int k = 0; k < SYNC; k++) m_hist.push_back('0);
        m_deb = '0; m_press = '0; m_rel = '0; m_pb = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic [W-1:0] pressed, input logic ph);
        logic [W-1:0] s;
        s = m_hist.pop_front();
        m_hist.push_back(pressed);
        if (!ph) m_pb = m_deb;
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < W; i++) begin
            m_run[i] = (s[i] != m_deb[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DEB) begin
                m_deb[i] = s[i];
                if (s[i]) m_press[i] = 1'b1;
                else      m_rel[i]   = 1'b1;
                m_run[i] = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply_cycle(input logic [W-1:0] pressed, input logic ph, input string tag);
        buttons_raw = to_raw(pressed);
        phase       = ph;
        @(posedge clock);
        model_step(pressed, ph);
        #1;
        check({tag, "_deb"},   debounced,     m_deb);
        check({tag, "_pb"},    pushbuttons,   m_pb);
        check({tag, "_press"}, press_pulse,   m_press);
        check({tag, "_rel"},   release_pulse, m_rel);
        check({tag, "_excl"},  press_pulse & release_pulse, '0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_deb"},   debounced,     '0);
        check({tag, "_rst_pb"},    pushbuttons,   '0);
        check({tag, "_rst_press"}, press_pulse,   '0);
        check({tag, "_rst_rel"},   release_pulse, '0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] pressed;
        logic         phase;
        logic [W-1:0] exp_deb;
        logic [W-1:0] exp_press;
        logic [W-1:0] exp_pb;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] cur;
        int           hits;
        logic         stuck;

        reset       = 1'b0;
        phase       = 1'b0;
        buttons_raw = to_raw('0);
        model_reset();

        // Clean press of bit0; phase held high on edges 6..8 to show pushbuttons waits.
        tbl[0] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[2] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[3] = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[4] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[5] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000};
        tbl[6] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[7] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[8] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0001};
        tbl[9] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0001};

        #2;
        do_reset("init");

        for (int v = 0; v < 10; v++) begin
            apply_cycle(tbl[v].pressed, tbl[v].phase, "clean");
            check("tbl_deb",   debounced,   tbl[v].exp_deb);
            check("tbl_press", press_pulse, tbl[v].exp_press);
            check("tbl_pb",    pushbuttons, tbl[v].exp_pb);
            $display("vec %0d: pressed=%b phase=%b deb=%b press=%b pb=%b", v,
                     tbl[v].pressed, tbl[v].phase, debounced, press_pulse, pushbuttons);
        end

        // Bounce on bit1: 1,0,1,0 then held; commit 6 edges after the final rise.
        do_reset("bounce");
        apply_cycle(4'b0010, 1'b0, "bounce");
        apply_cycle(4'b0000, 1'b0, "bounce");
        apply_cycle(4'b0010, 1'b0, "bounce");
        apply_cycle(4'b0000, 1'b0, "bounce");
        for (int e = 1; e <= 8; e++) begin
            apply_cycle(4'b0010, 1'b0, "bounce");
            if (e == 5) check("bounce_edge5", debounced, 4'b0000);
            if (e == 6) check("bounce_edge6", debounced, 4'b0010);
        end
        $display("bounce: deb=%b pb=%b", debounced, pushbuttons);

        // Three-cycle glitch on bit2 must leave every output quiet.
        do_reset("glitch");
        stuck = 1'b0;
        for (int c = 0; c < 12; c++) begin
            apply_cycle((c < 3) ? 4'b0100 : 4'b0000, c[0], "glitch");
            if ((debounced | press_pulse | pushbuttons) != '0) stuck = 1'b1;
        end
        check("glitch_quiet", {3'b000, stuck}, 4'b0000);
        check("glitch_cnt", {2'b00, dut.g_bit[2].u_bit.cnt_q}, 4'b0000);
        $display("glitch: deb=%b press=%b pb=%b", debounced, press_pulse, pushbuttons);

        // Bits 0 and 3 pressed and released together.
        do_reset("simul");
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            apply_cycle(4'b1001, 1'b0, "simul");
            if (press_pulse == 4'b1001) hits++;
        end
        check("simul_press_once", 4'(hits), 4'd1);
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            apply_cycle(4'b0000, 1'b0, "simul");
            if (release_pulse == 4'b1001) hits++;
        end
        check("simul_release_once", 4'(hits), 4'd1);
        check("simul_deb_final", debounced, 4'b0000);
        $display("simul: deb=%b pb=%b", debounced, pushbuttons);

        // Reset while bit0 is mid-count and bit3 is already committed.
        do_reset("midrst");
        for (int c = 0; c < 8; c++) apply_cycle(4'b1000, 1'b0, "midrst_pre");
        check("midrst_pre_deb", debounced, 4'b1000);
        for (int c = 0; c < 4; c++) apply_cycle(4'b1001, 1'b0, "midrst_cnt");
        #2;
        do_reset("midrst");
        for (int e = 1; e <= 8; e++) begin
            apply_cycle(4'b1001, 1'b0, "midrst_post");
            if (e == 5) check("midrst_press_e5", press_pulse, 4'b0000);
            if (e == 6) check("midrst_press_e6", press_pulse, 4'b1001);
        end
        $display("midrst: deb=%b press=%b pb=%b", debounced, press_pulse, pushbuttons);

        // Random presses, bounces and phase, with one reset in the middle.
        do_reset("rand");
        cur = '0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) cur[$urandom_range(0, W-1)] ^= 1'b1;
            if (c == 400) begin
                #2;
                do_reset("rand_mid");
            end
            apply_cycle(cur, 1'($urandom_range(0, 1)), "rand");
        end
        $display("random: 800 cycles, deb=%b pb=%b", debounced, pushbuttons);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pushbutton_conditioner.md
Name: pushbutton_conditioner

Overview:
Input-side stage that sits directly upstream of the processor's pushbuttons data input. It synchronises raw board switches into the clock domain, debounces each bit independently, and presents a clean nibble to the processor. The nibble is updated only at fetch-phase edges, so the value the processor reads with IN is constant for the whole execute cycle. It also provides one-cycle press pulses for other consumers, such as test LEDs or interrupt experiments.

Parameters:
WIDTH, 4, number of button bits
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to commit a change (>=2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
phase  input  1  processor phase bit (0 = fetch cycle, 1 = execute cycle)
buttons_raw  input  WIDTH  unsynchronised switch levels
pushbuttons  output  WIDTH  debounced, phase-aligned value to the processor
press_pulse  output  WIDTH  one-cycle pulse per bit on debounced 0->1
release_pulse  output  WIDTH  one-cycle pulse per bit on debounced 1->0
debounced  output  WIDTH  debounced level before phase alignment

Behaviour:
- Interface: one clock, `clock`; reset is asynchronous and active-high, `reset`. Every flop is cleared by reset.
- Reset values:
  - All synchroniser flops, debounced, pushbuttons, press_pulse and release_pulse are 0.
  - All counters are 0.
  - Every per-bit FSM is in IDLE_LOW.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit. sync[i] is the last stage. No logic sits between stages.
- Per-bit FSM, 4 states: IDLE_LOW, CONFIRM_HIGH, IDLE_HIGH, CONFIRM_LOW. Counter width is $clog2(DEBOUNCE_CYCLES).
  - IDLE_LOW: if sync=1, go to CONFIRM_HIGH with cnt=1.
  - CONFIRM_HIGH:
    - sync=0: back to IDLE_LOW, cnt=0.
    - sync=1 and cnt==DEBOUNCE_CYCLES-1: go to IDLE_HIGH, debounced<=1, press_pulse<=1, cnt=0.
    - Otherwise: cnt++.
  - IDLE_HIGH and CONFIRM_LOW: symmetric, with release_pulse.
- Latency: a held raw change reaches debounced at exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Glitches: any raw excursion held for fewer than DEBOUNCE_CYCLES synchronised cycles produces no change on any output.
- Pulses: press_pulse and release_pulse are registered and high for exactly one cycle, coincident with the debounced transition. They are never both high on the same bit.
- Phase alignment: pushbuttons <= debounced only at edges where phase==0. At edges where phase==1, pushbuttons holds its value.
- Bit independence: each bit's state and counter are fully independent. Simultaneous changes on several bits commit on the same edge if their raw timing is identical.
- Counter: never wraps. The maximum value reached is DEBOUNCE_CYCLES-1.
- Reset mid-count: the FSM returns to IDLE_LOW and no pulse is emitted. A button still held after reset is re-debounced from scratch and produces a press_pulse.

Optional Feature:
PB_ACTIVE_LOW_EN
- Defined: buttons_raw is inverted before the first synchroniser stage, so a raw 0 means pressed. Reset state is still logical "released", i.e. all debounced outputs are 0.
- Undefined: buttons_raw is used as-is, so a raw 1 means pressed.
- No other behaviour differs between the two builds.

Decomposition:
- Shared package pb_pkg:
  - State encoding typedef (IDLE_LOW=2'b00, CONFIRM_HIGH=2'b01, IDLE_HIGH=2'b10, CONFIRM_LOW=2'b11).
  - Default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
- Sub-module debounce_bit: synchroniser, FSM, counter and pulse flops for one bit. The top level instantiates WIDTH copies in a generate loop and adds the phase-aligned pushbuttons register.

Test Plan:
- Bench configuration for all scenarios: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Clean press: buttons_raw 0000->0001, held.
  - debounced=0001 and press_pulse=0001 for one cycle, both at the 6th edge.
  - pushbuttons=0001 at the first subsequent edge with phase==0; it never changes while phase==1.
- Bounce: bit1 toggles 1,0,1,0 on consecutive cycles, then holds 1.
  - No output change during toggling.
  - debounced[1]=1 exactly 6 edges after the final rising raw edge.
- Short glitch: bit2 raw high for 3 cycles, then low.
  - debounced, pushbuttons and press_pulse stay 0000 throughout.
  - Counter returns to 0.
- Release and simultaneous bits: bits 0 and 3 are pressed together, stabilise, then are released together.
  - press_pulse=1001 on one edge.
  - Later, release_pulse=1001 on one edge.
  - debounced returns to 0000.
- Reset mid-count: bit0 held high; reset asserted asynchronously after 4 edges, released after 2 edges.
  - All outputs go to 0 immediately on assertion.
  - After release, press_pulse[0] fires 6 edges after the first post-reset edge.
- PB_ACTIVE_LOW_EN defined: buttons_raw idles at 1111; bit0 driven to 0, held.
  - debounced=0001 at the 6th edge.
  - No output is nonzero before that edge, including immediately after reset.
